fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_ctrl_pkg.sv | 9 +
 rtl/rr_pick.sv | 18 +
 rtl/fifo_wr_arbiter.sv | 71 +++++++
 tb/tb_fifo_wr_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state type, default widths and free-space helper for the FIFO controllers
package fifo_ctrl_pkg;
  localparam int ADDR_W = $clog2(1024);
  localparam int GNT_W = $clog2(4);
  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
  function automatic int free_space(input int depth, input int usedw);
    return depth - usedw;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks the first valid index searching upward from i_ptr+1, wrapping at N
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  // scan farthest first so the nearest valid index wins
  always_comb begin
    o_idx = '0;
    for (int k = N; k >= 1; k--)
      if (i_valid[(int'(i_ptr) + k) % N]) o_idx = W'((int'(i_ptr) + k) % N);
  end
  assign o_any = |i_valid;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin whole-burst arbiter sharing one FIFO write port, with sclr sequencing
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_WIDTH = 1024,
  parameter int MAX_BURST = 16,
  localparam int AW = $clog2(DEPTH_WIDTH),
  localparam int GW = $clog2(N_REQ),
  localparam int CW = $clog2(MAX_BURST) + 1
) (
  input  logic                        wr_clk,
  input  logic                        aclr,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic                        fifo_wrreq,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_sclr,
  input  logic                        fifo_full,
  input  logic [AW:0]                 fifo_usedw,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);
  state_t r_state, w_next;
  logic [GW-1:0] r_grant, r_rr_ptr, w_pick;
  logic [CW-1:0] r_beat_cnt;
  logic w_any, w_room, w_accept, w_end;
  rr_pick #(.N(N_REQ)) u_pick (
    .i_valid(req_valid),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );
  // admit only when a maximum-length burst is guaranteed to fit
  assign w_room = free_space(DEPTH_WIDTH, int'(fifo_usedw)) >= MAX_BURST;
  assign w_accept = (r_state == BURST) & req_valid[r_grant] & ~fifo_full;
  assign w_end = w_accept & (req_last[r_grant] | (r_beat_cnt == CW'(MAX_BURST - 1)));
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (flush_req ? FLUSH : (w_any & w_room) ? BURST : IDLE)
           : r_state == BURST ? (w_end ? IDLE : BURST)
           : IDLE;
  end
  always_ff @(posedge wr_clk or posedge aclr)
    if (aclr) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= GW'(N_REQ - 1);
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == BURST) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_end) r_rr_ptr <= r_grant;
    end
  assign req_ready  = (r_state == BURST && !fifo_full) ? N_REQ'(1) << r_grant : '0;
  assign fifo_wrreq = w_accept;
  assign fifo_data  = r_state == BURST ? req_data[r_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign fifo_sclr  = r_state == FLUSH;
  assign flush_done = r_state == FLUSH;
  assign grant_id   = r_grant;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios checked every cycle against a transaction-level arbiter model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, DEPTH = 1024, MB = 16, UW = 11, GW = 2;
  logic wr_clk = 0, aclr = 1;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic flush_req, flush_done, fifo_wrreq, fifo_sclr, fifo_full, busy;
  logic [DW-1:0] fifo_data;
  logic [UW-1:0] fifo_usedw;
  logic [GW-1:0] grant_id;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .DEPTH_WIDTH(DEPTH), .MAX_BURST(MB)) dut (
    .wr_clk(wr_clk), .aclr(aclr), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .flush_req(flush_req),
    .flush_done(flush_done), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .fifo_sclr(fifo_sclr), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0, errors = 0;
  int rem[N], seq[N], blen[N];
  int usedw;
  bit force_full;
  int m_owner, m_ptr, m_gid, m_cnt;
  bit m_flush;
  int grants[$];
  int writes[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // requester streams and FIFO occupancy, presented to the DUT
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rem[i] > 0;
      req_last[i]  = rem[i] == 1 || (blen[i] > 0 && seq[i] % blen[i] == blen[i] - 1);
      req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
    end
    fifo_usedw = UW'(usedw);
    fifo_full  = usedw >= DEPTH || force_full;
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_gid = 0; m_cnt = 0; m_flush = 0;
  endtask

  task automatic check_cycle();
    logic [N-1:0] er;
    logic ew;
    logic [DW-1:0] ed;
    er = '0; ew = 0; ed = '0;
    if (m_owner >= 0) begin
      if (!fifo_full) er[m_owner] = 1'b1;
      ew = req_valid[m_owner] && !fifo_full;
      ed = req_data[m_owner*DW +: DW];
    end
    chk("busy", busy, m_owner >= 0 || m_flush);
    chk("grant_id", grant_id, m_gid);
    chk("req_ready", req_ready, er);
    chk("fifo_wrreq", fifo_wrreq, ew);
    chk("fifo_data", fifo_data, ed);
    chk("fifo_sclr", fifo_sclr, m_flush);
    chk("flush_done", flush_done, m_flush);
  endtask

  // one clock of the abstract arbiter: who owns the port, what got written
  task automatic advance();
    int o;
    bit acc, fin, found;
    o = m_owner;
    acc = o >= 0 && req_valid[o] && !fifo_full;
    fin = acc && (req_last[o] || m_cnt == MB - 1);
    if (acc) begin writes.push_back(o); usedw++; seq[o]++; rem[o]--; end
    if (m_flush) begin
      m_flush = 0; usedw = 0; flush_req = 0;
    end else if (o < 0) begin
      if (flush_req) m_flush = 1;
      else if (req_valid != 0 && DEPTH - int'(fifo_usedw) >= MB) begin
        found = 0;
        for (int k = 1; k <= N; k++)
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1; m_owner = (m_ptr + k) % N;
          end
        m_gid = m_owner; m_cnt = 0; grants.push_back(m_owner);
      end
    end else if (acc) begin
      m_cnt++;
      if (fin) begin m_ptr = o; m_owner = -1; end
    end
    drive();
    #1;
  endtask

  task automatic step();
    @(negedge wr_clk);
    check_cycle();
    @(posedge wr_clk);
    #1;
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    aclr = 1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; blen[i] = 0; end
    usedw = 0; force_full = 0; flush_req = 0;
    model_reset();
    grants.delete(); writes.delete();
    drive();
    #1;
    @(negedge wr_clk);
    check_cycle();
    aclr = 0;
    @(posedge wr_clk);
    #1;
    advance();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; blen[i] = 0; end
    usedw = 0; force_full = 0; flush_req = 0;
    model_reset();
    drive();
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    check_cycle();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    aclr = 0;
    @(posedge wr_clk);
    #1;
    advance();

    // 1: single 3-beat burst, one arbitration cycle first
    rem[0] = 3; drive(); #1;
    chk("t1_arb_busy", busy, 0);
    chk("t1_arb_wrreq", fifo_wrreq, 0);
    step();
    chk("t1_b1_busy", busy, 1);
    chk("t1_b1_wrreq", fifo_wrreq, 1);
    step(); chk("t1_b2_wrreq", fifo_wrreq, 1);
    step(); chk("t1_b3_wrreq", fifo_wrreq, 1);
    step();
    chk("t1_end_busy", busy, 0);
    chk("t1_usedw", usedw, 3);
    chk("t1_grant", grant_id, 0);

    // 2: four requesters, 2-beat bursts
    pulse_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 4; blen[i] = 2; end
    drive(); #1;
    run(30);
    chk("t2_ngrants", grants.size(), 8);
    for (int i = 0; i < 5; i++) chk("t2_order", grants[i], i % 4);
    for (int i = 0; i < 8; i++) chk("t2_beats", writes[i], i / 2);

    // 3: 20-beat stream truncated at 16 beats
    pulse_reset();
    rem[2] = 20; drive(); #1;
    step();
    rem[3] = 2; rem[0] = 2; rem[1] = 2; drive(); #1;
    run(40);
    chk("t3_ngrants", grants.size(), 5);
    chk("t3_g0", grants[0], 2);
    chk("t3_g1", grants[1], 3);
    chk("t3_g2", grants[2], 0);
    chk("t3_g3", grants[3], 1);
    chk("t3_g4", grants[4], 2);
    chk("t3_nbeats", writes.size(), 26);
    chk("t3_beat16", writes[15], 2);
    chk("t3_beat17", writes[16], 3);
    chk("t3_resume", writes[22], 2);

    // 4: admission threshold, then full stalls
    pulse_reset();
    usedw = 1010; rem[1] = 4; drive(); #1;
    run(5);
    chk("t4_no_grant", grants.size(), 0);
    chk("t4_idle", busy, 0);
    usedw = 1008; drive(); #1;
    step();
    chk("t4_granted", busy, 1);
    run(2);
    force_full = 1; drive(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_full_ready", req_ready, 0);
      chk("t4_full_wrreq", fifo_wrreq, 0);
      chk("t4_full_grant", grant_id, 1);
      step();
    end
    force_full = 0; drive(); #1;
    run(5);
    chk("t4_usedw", usedw, 1012);
    chk("t4_done", busy, 0);

    // 5: flush requested mid-burst waits for the burst
    pulse_reset();
    rem[0] = 4; drive(); #1;
    run(2);
    flush_req = 1; drive(); #1;
    run(3);
    chk("t5_gap_busy", busy, 0);
    chk("t5_gap_sclr", fifo_sclr, 0);
    chk("t5_all_beats", usedw, 4);
    step();
    chk("t5_sclr", fifo_sclr, 1);
    chk("t5_done", flush_done, 1);
    chk("t5_no_wr", fifo_wrreq, 0);
    step();
    chk("t5_after_sclr", fifo_sclr, 0);
    chk("t5_cleared", usedw, 0);

    // 6: asynchronous reset on beat 3
    pulse_reset();
    rem[1] = 4; drive(); #1;
    run(3);
    #2;
    aclr = 1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_wrreq", fifo_wrreq, 0);
    chk("t6_data", fifo_data, 0);
    chk("t6_grant", grant_id, 0);
    model_reset();
    usedw = 0; grants.delete(); writes.delete();
    rem[0] = 2; drive(); #1;
    @(negedge wr_clk);
    check_cycle();
    aclr = 0;
    @(posedge wr_clk);
    #1;
    advance();
    run(10);
    chk("t6_next_grant", grants.size() > 0 ? grants[0] : -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
